poly_mul_rq_par: RTL and testbench

Digit-serial cyclic polynomial multiplier for the NTRU-HRSS R_q datapath. It computes e = r·h mod (x^N − 1) with all coefficients taken mod 2^Q_W. r is a ternary polynomial (2-bit trits); h is a full-width R_q polynomial. It generalises the one-trit-per-cycle multiplier to P trits per cycle, adds a start/busy/done handshake and input capture, and handles N not divisible by P. It sits between the key/encapsulation control FSM and the R_q→S3 conversion stage.

---
 rtl/poly_mul_rq_par.sv | 198 +++++++++++++++++++
 tb/tb_poly_mul_rq_par.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/poly_mul_rq_par.sv
// poly_mul_rq_par: digit-serial cyclic multiplier e = r*h mod (x^N - 1) over Z_(2^Q_W).
// r is ternary (2-bit trits, 01=+1, 11=-1, else 0); P trits are folded in per clock.
// Optional feature macro: POLY_MUL_PHI_REDUCE_EN adds the mod_phi port and a FOLD
// cycle that reduces the product modulo Phi_N (e_i = acc_i - acc_(N-1)).
module poly_mul_rq_par #(
  parameter int N   = 701,
  parameter int Q_W = 13,
  parameter int R_W = 2,
  parameter int P   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N*R_W-1:0]   r,
  input  logic [N*Q_W-1:0]   h,
`ifdef POLY_MUL_PHI_REDUCE_EN
  input  logic               mod_phi,
`endif
  output logic               busy,
  output logic               done,
  output logic [N*Q_W-1:0]   e
);

  // Number of RUN cycles, and the padded trit count seen by the shifter.
  localparam int C     = (N + P - 1) / P;
  localparam int CP    = C * P;
  localparam int CNT_W = $clog2(C + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
`ifdef POLY_MUL_PHI_REDUCE_EN
    , S_FOLD = 2'd2
`endif
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CP*R_W-1:0]   r_sh_reg;
  logic [N*Q_W-1:0]    h_reg;
  logic [N*Q_W-1:0]    acc_reg;
  logic [N*Q_W-1:0]    e_reg;
  logic                done_reg;

  logic                load_en;
  logic                run_en;
  logic                e_load;
  logic [N*Q_W-1:0]    acc_chain;
  logic [N*Q_W-1:0]    acc_prev;
  logic [Q_W-1:0]      coef;
  logic [R_W-1:0]      grp_trit [P];

`ifdef POLY_MUL_PHI_REDUCE_EN
  logic                mod_phi_reg;
  logic                fold_en;
  logic [N*Q_W-1:0]    fold_val;
`endif

  // The captured r sits left-aligned with zero padding on top; the top P trits
  // are the current group, highest index first. Padding trits decode as zero.
  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_trit
      assign grp_trit[gi] = r_sh_reg[(CP-1-gi)*R_W +: R_W];
    end
  endgenerate

`ifdef POLY_MUL_PHI_REDUCE_EN
  // Reduction mod Phi_N: subtract the top coefficient from every coefficient.
  generate
    for (gi = 0; gi < N; gi++) begin : g_fold
      assign fold_val[gi*Q_W +: Q_W] = acc_reg[gi*Q_W +: Q_W] - acc_reg[(N-1)*Q_W +: Q_W];
    end
  endgenerate
`endif

  // Chain P Horner steps combinationally: acc <- rot(acc) + r_j*h for each trit.
  always_comb begin
    acc_chain = acc_reg;
    acc_prev  = '0;
    coef      = '0;
    for (int s = 0; s < P; s++) begin
      acc_prev = acc_chain;
      for (int i = 0; i < N; i++) begin
        coef = acc_prev[((i + N - 1) % N)*Q_W +: Q_W];
        if (grp_trit[s] == 2'b01)
          coef = coef + h_reg[i*Q_W +: Q_W];
        else if (grp_trit[s] == 2'b11)
          coef = coef - h_reg[i*Q_W +: Q_W];
        acc_chain[i*Q_W +: Q_W] = coef;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state and control strobes.
  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    run_en     = 1'b0;
    e_load     = 1'b0;
`ifdef POLY_MUL_PHI_REDUCE_EN
    fold_en    = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          load_en    = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        run_en = 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
`ifdef POLY_MUL_PHI_REDUCE_EN
          if (mod_phi_reg) begin
            state_next = S_FOLD;
          end else begin
            e_load     = 1'b1;
            state_next = S_IDLE;
          end
`else
          e_load     = 1'b1;
          state_next = S_IDLE;
`endif
        end
      end
`ifdef POLY_MUL_PHI_REDUCE_EN
      S_FOLD: begin
        fold_en    = 1'b1;
        state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, accumulator update and digit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_reg <= '0;
      h_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
    end else if (load_en) begin
      r_sh_reg <= (CP*R_W)'(r);
      h_reg    <= h;
      acc_reg  <= '0;
      cnt_reg  <= CNT_W'(C);
    end else if (run_en) begin
      r_sh_reg <= r_sh_reg << (P*R_W);
      acc_reg  <= acc_chain;
      cnt_reg  <= cnt_reg - 1'b1;
    end
  end

`ifdef POLY_MUL_PHI_REDUCE_EN
  // mod_phi is captured together with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mod_phi_reg <= 1'b0;
    else if (load_en)
      mod_phi_reg <= mod_phi;
  end
`endif

  // Result register and done pulse; e only moves on the done-producing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
`ifdef POLY_MUL_PHI_REDUCE_EN
      if (e_load)
        e_reg <= acc_chain;
      else if (fold_en)
        e_reg <= fold_val;
      done_reg <= e_load | fold_en;
`else
      if (e_load)
        e_reg <= acc_chain;
      done_reg <= e_load;
`endif
    end
  end

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;
  assign e    = e_reg;

endmodule

// File: tb/tb_poly_mul_rq_par.sv
// tb_poly_mul_rq_par: directed checks of poly_mul_rq_par with N=7, Q_W=13 and
// P = 1, 3, 7 (one instance each). Mod-Phi checks run when POLY_MUL_PHI_REDUCE_EN is set.
module tb_poly_mul_rq_par;

  localparam int N  = 7;
  localparam int QW = 13;

  logic              clk;
  logic              rst_n;
  logic              start_s   [3];
  logic [N*2-1:0]    r_s       [3];
  logic [N*QW-1:0]   h_s       [3];
  logic              mod_phi_s [3];
  logic              busy_s    [3];
  logic              done_s    [3];
  logic [N*QW-1:0]   e_s       [3];

  int total;
  int bad;
  int n_cyc;

  poly_mul_rq_par #(.N(N), .Q_W(QW), .R_W(2), .P(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .r(r_s[0]), .h(h_s[0]),
`ifdef POLY_MUL_PHI_REDUCE_EN
    .mod_phi(mod_phi_s[0]),
`endif
    .busy(busy_s[0]), .done(done_s[0]), .e(e_s[0]));

  poly_mul_rq_par #(.N(N), .Q_W(QW), .R_W(2), .P(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .r(r_s[1]), .h(h_s[1]),
`ifdef POLY_MUL_PHI_REDUCE_EN
    .mod_phi(mod_phi_s[1]),
`endif
    .busy(busy_s[1]), .done(done_s[1]), .e(e_s[1]));

  poly_mul_rq_par #(.N(N), .Q_W(QW), .R_W(2), .P(7)) u_p7 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .r(r_s[2]), .h(h_s[2]),
`ifdef POLY_MUL_PHI_REDUCE_EN
    .mod_phi(mod_phi_s[2]),
`endif
    .busy(busy_s[2]), .done(done_s[2]), .e(e_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never finishes.
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*QW-1:0] ph(input int c0, input int c1, input int c2,
                                         input int c3, input int c4, input int c5,
                                         input int c6);
    ph = {13'(c6), 13'(c5), 13'(c4), 13'(c3), 13'(c2), 13'(c1), 13'(c0)};
  endfunction

  task automatic check(input string tag, input logic [N*QW-1:0] obs, input logic [N*QW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one cycle; on return the start edge has passed.
  task automatic launch(input int k, input logic [N*2-1:0] rv, input logic [N*QW-1:0] hv);
    @(negedge clk);
    r_s[k]     = rv;
    h_s[k]     = hv;
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    n_cyc      = 1;
    check("busy_after_start", 91'(busy_s[k]), 91'(1));
    check("done_after_start", 91'(done_s[k]), 91'(0));
  endtask

  // n_cyc counts rising edges since (and including) the start edge.
  task automatic wait_done(input int k, input int lat, input logic [N*QW-1:0] exp_e, input string tag);
    while (done_s[k] !== 1'b1 && n_cyc < 60) begin
      @(negedge clk);
      n_cyc++;
    end
    $display("txn %s: latency=%0d e=%0h", tag, n_cyc, e_s[k]);
    check({tag, "_lat"}, 91'(n_cyc), 91'(lat));
    check({tag, "_e"}, e_s[k], exp_e);
    check({tag, "_busy_at_done"}, 91'(busy_s[k]), 91'(0));
  endtask

  task automatic run_op(input int k, input logic [N*2-1:0] rv, input logic [N*QW-1:0] hv,
                        input int lat, input logic [N*QW-1:0] exp_e, input string tag);
    launch(k, rv, hv);
    wait_done(k, lat, exp_e, tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 91'(done_s[k]), 91'(0));
    check({tag, "_e_held"}, e_s[k], exp_e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_cyc = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_s[k]   = 1'b0;
      r_s[k]       = '0;
      h_s[k]       = '0;
      mod_phi_s[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_e", e_s[k], '0);
      check("rst_busy", 91'(busy_s[k]), 91'(0));
      check("rst_done", 91'(done_s[k]), 91'(0));
    end
    rst_n = 1'b1;

    // P=1: r = x, h = 1..7 -> cyclic shift by one.
    run_op(0, 14'h0004, ph(1,2,3,4,5,6,7), 8, ph(7,1,2,3,4,5,6), "p1_x1");
    // P=3 (two padding trits): r = -1, h = 1 -> e0 = -1.
    run_op(1, 14'h0003, ph(1,0,0,0,0,0,0), 4, ph(8191,0,0,0,0,0,0), "p3_neg");
    // Trit 10 is zero.
    run_op(1, 14'h0002, ph(1,0,0,0,0,0,0), 4, '0, "p3_t10");
    // r = x^6 lands in the padded first group.
    run_op(1, 14'h1000, ph(1,2,3,4,5,6,7), 4, ph(2,3,4,5,6,7,1), "p3_x6");
    // P=7: all +1 times all -1 -> each coefficient 7*(-1).
    run_op(2, 14'h1555, {7{13'h1fff}}, 2, {7{13'd8185}}, "p7_all");
    // r = 1 - x: e_i = h_i - h_(i-1).
    run_op(2, 14'h000D, ph(1,2,3,4,5,6,7), 2, ph(8186,1,1,1,1,1,1), "p7_1mx");

    // start and new operands while busy are ignored.
    launch(0, 14'h0004, ph(1,2,3,4,5,6,7));
    @(negedge clk);
    n_cyc++;
    r_s[0]     = 14'h1000;
    h_s[0]     = ph(9,9,9,9,9,9,9);
    start_s[0] = 1'b1;
    @(negedge clk);
    n_cyc++;
    start_s[0] = 1'b0;
    wait_done(0, 8, ph(7,1,2,3,4,5,6), "p1_ignore");

    // Reset in the middle of RUN abandons the operation immediately.
    launch(0, 14'h0004, ph(1,2,3,4,5,6,7));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 91'(busy_s[0]), 91'(0));
    check("midrst_done", 91'(done_s[0]), 91'(0));
    check("midrst_e", e_s[0], '0);
    check("midrst_e_p7", e_s[2], '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 14'h0001, ph(1,2,3,4,5,6,7), 8, ph(1,2,3,4,5,6,7), "p1_after_rst");

    // Back-to-back: start held through the done cycle is accepted there.
    launch(1, 14'h1000, ph(1,2,3,4,5,6,7));
    @(negedge clk);
    n_cyc++;
    r_s[1]     = 14'h0003;
    h_s[1]     = ph(1,0,0,0,0,0,0);
    start_s[1] = 1'b1;
    wait_done(1, 4, ph(2,3,4,5,6,7,1), "b2b_first");
    @(negedge clk);
    start_s[1] = 1'b0;
    n_cyc      = 1;
    check("b2b_busy", 91'(busy_s[1]), 91'(1));
    check("b2b_done_low", 91'(done_s[1]), 91'(0));
    check("b2b_e_stable", e_s[1], ph(2,3,4,5,6,7,1));
    wait_done(1, 4, ph(8191,0,0,0,0,0,0), "b2b_second");

`ifdef POLY_MUL_PHI_REDUCE_EN
    // Mod-Phi fold: e_i = h_i - h_6 for r = 1; one extra cycle.
    mod_phi_s[0] = 1'b1;
    run_op(0, 14'h0001, ph(9,0,0,0,0,0,5), 9, ph(4,8187,8187,8187,8187,8187,0), "phi_on");
    mod_phi_s[0] = 1'b0;
    run_op(0, 14'h0001, ph(9,0,0,0,0,0,5), 8, ph(9,0,0,0,0,0,5), "phi_off");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
